prog_rom_port_sched: RTL and testbench
======================================

// Module: prog_rom_port_sched
// PURPOSE
// - Shares the single synchronous read port of the 1024x18 program ROM between three requesters.
// - Requesters, in priority order: MCU instruction fetch, debug readback, built-in checksum scan engine.
// - Sits between the MCU program counter and the ROM. Tracks which requester owns each in-flight read
//   (ROM latency is 1 cycle) and returns data to the correct owner.
// PARAMETERS
// AW        10    ROM address width
// DW        18    ROM data width
// DEPTH     1024  words covered by checksum scan
// MAX_WAIT  16    cycles a debug request may be blocked by fetch before it is forced through (>=1)
// PORTS
// CLK         in   1   system clock; all state on rising edge
// RST_N       in   1   asynchronous active-low reset
// CPU_REQ     in   1   MCU fetch request this cycle
// CPU_ADDR    in   AW  MCU fetch address (PC)
// CPU_STALL   out  1   fetch not granted this cycle; MCU must hold PC and CPU_REQ
// CPU_IR      out  DW  fetched instruction; valid when CPU_IR_VLD
// CPU_IR_VLD  out  1   CPU_IR valid (one cycle after grant)
// DBG_VALID   in   1   debug read request; held with DBG_ADDR until DBG_READY
// DBG_ADDR    in   AW  debug read address
// DBG_READY   out  1   debug request accepted this cycle
// DBG_DATA    out  DW  debug read data; valid when DBG_DVLD
// DBG_DVLD    out  1   single-cycle pulse, one cycle after DBG_READY
// SCAN_START  in   1   pulse: start checksum over addresses 0..DEPTH-1
// SCAN_BUSY   out  1   scan in progress
// SCAN_DONE   out  1   single-cycle pulse when SCAN_SUM final
// SCAN_SUM    out  DW  sum of all words mod 2^DW; held until next start
// ROM_ADDR    out  AW  to ROM read address
// ROM_DATA    in   DW  ROM registered output (addr presented at edge N -> data after edge N+1)
// BEHAVIOUR
// - Reset values:
//   - All outputs 0; ROM_ADDR = 0.
//   - Owner tag = NONE; wait counter = 0; scan FSM = IDLE.
// - Grant each cycle (exactly one owner or none). ROM_ADDR is combinational from the winner:
//   1) DBG, if DBG_VALID and wait counter == MAX_WAIT (forced slot; CPU_STALL=1 if CPU_REQ).
//   2) CPU, if CPU_REQ.
//   3) DBG, if DBG_VALID.
//   4) SCAN, if FSM in RUN.
//   - No winner: ROM_ADDR holds its previous value.
// - CPU_STALL = CPU_REQ and CPU not granted.
// - DBG_READY = DBG granted.
// - Owner tag register records the winner. Next cycle:
//   - ROM_DATA is routed to CPU_IR (with CPU_IR_VLD), DBG_DATA (with DBG_DVLD), or the scan accumulator.
//   - CPU_IR/DBG_DATA hold their last value when their valid is low.
// - Wait counter:
//   - Increments each cycle DBG_VALID is high and DBG is not granted, saturating at MAX_WAIT.
//   - Clears on DBG grant or when DBG_VALID is low.
//   - Worst-case debug latency: MAX_WAIT+1 cycles.
// - Scan FSM (IDLE/RUN/DRAIN/DONE):
//   - IDLE: SCAN_START -> RUN; scan addr = 0, sum = 0, SCAN_BUSY = 1.
//   - RUN: on SCAN grant, addr++. Grant with addr == DEPTH-1 -> DRAIN. No grant -> stay, addr unchanged.
//   - Accumulate: sum += ROM_DATA (mod 2^DW) on every cycle the tag == SCAN.
//   - DRAIN: one cycle for last data; -> DONE.
//   - DONE: SCAN_DONE = 1 for one cycle, SCAN_BUSY -> 0; -> IDLE.
//   - SCAN_START while busy is ignored. SCAN_SUM updates only on entry to DONE.
// - Simultaneous events:
//   - SCAN_START in the same cycle as CPU and DBG requests: scan waits, with no starvation guarantee.
//   - DBG_VALID dropped before READY: the request is withdrawn; no data is returned.
// - Reset mid-operation:
//   - In-flight read is discarded; no IR_VLD/DVLD pulse follows.
//   - Scan aborts; SCAN_SUM returns to 0.
// TESTING
// - CPU_REQ=1 continuous, addr 0..7, ROM[i]=i+0x100 -> CPU_IR_VLD every cycle, CPU_IR=0x100..0x107, one-cycle lag, STALL=0.
// - CPU idle, DBG_VALID addr 0x3FF (ROM=0x2ABCD) -> DBG_READY same cycle, DBG_DVLD next cycle with 0x2ABCD.
// - CPU_REQ=1 continuous + DBG_VALID, MAX_WAIT=16 -> DBG_READY on 17th cycle, CPU_STALL=1 that cycle only, PC held, then fetch resumes.
// - SCAN_START, ROM all 0x00001, no other traffic -> SCAN_DONE after 1024+2 cycles, SCAN_SUM=0x00400.
// - Scan with CPU fetching every other cycle; ROM[i]=0x3FFFF -> SCAN_SUM=0x3FC00 (wrap mod 2^18); CPU data uncorrupted.
// - RST_N low during scan and during a DBG grant -> no DVLD pulse, all outputs 0, SCAN_BUSY=0; new scan afterwards correct.

Source files
------------

// File: rtl/prog_rom_port_sched.sv
// prog_rom_port_sched
// Arbitrates the single synchronous read port of the program ROM between
// three requesters: MCU instruction fetch, debug readback and the checksum
// scan engine, in that priority order. Debug gets a forced slot once fetch
// has blocked it for MAX_WAIT cycles. An owner tag follows each read through
// the one-cycle ROM latency and steers the returned word to its requester.
//
// Ports
//   prog_clk, rst_n          clock, async active-low reset
//   cpu_req, cpu_addr        fetch request / PC
//   cpu_stall                fetch not granted; MCU holds PC and request
//   cpu_ir, cpu_ir_vld       fetched word, valid one cycle after grant
//   dbg_valid, dbg_addr      debug read request (held until dbg_ready)
//   dbg_ready                debug request granted this cycle
//   dbg_data, dbg_dvld       debug read word, one-cycle pulse after grant
//   scan_start               pulse: checksum addresses 0..DEPTH-1
//   scan_busy, scan_done     scan in progress / final-sum pulse
//   scan_sum                 sum of all words mod 2^DW
//   rom_addr, rom_data       ROM read address / registered ROM output
//
// Scan FSM
//   state   | meaning
//   S_IDLE  | waiting for scan_start
//   S_RUN   | issuing scan reads whenever the port is otherwise free
//   S_DRAIN | last scan word returning from the ROM
//   S_DONE  | scan_sum final, scan_done pulses
module prog_rom_port_sched #(
   parameter int AW       = 10,
   parameter int DW       = 18,
   parameter int DEPTH    = 1024,
   parameter int MAX_WAIT = 16
) (
   input  logic          prog_clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   output logic          cpu_stall,
   output logic [DW-1:0] cpu_ir,
   output logic          cpu_ir_vld,
   input  logic          dbg_valid,
   input  logic [AW-1:0] dbg_addr,
   output logic          dbg_ready,
   output logic [DW-1:0] dbg_data,
   output logic          dbg_dvld,
   input  logic          scan_start,
   output logic          scan_busy,
   output logic          scan_done,
   output logic [DW-1:0] scan_sum,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
   localparam logic [AW-1:0] SCAN_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG, OWN_SCAN} owner_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} scan_st_t;

   owner_t          winner;
   owner_t          tag_q;
   scan_st_t        scan_st;
   scan_st_t        scan_nxt;
   logic [WW-1:0]   wait_cnt;
   logic [AW-1:0]   rom_addr_q;
   logic [AW-1:0]   scan_addr;
   logic [DW-1:0]   scan_acc;
   logic [DW-1:0]   scan_acc_nxt;
   logic [DW-1:0]   cpu_ir_q;
   logic [DW-1:0]   dbg_data_q;

   // Port grant; with no winner the address bus keeps its last value.
   always_comb begin
      winner   = OWN_NONE;
      rom_addr = rom_addr_q;
      if (dbg_valid && (wait_cnt == WAIT_MAX)) begin
         winner   = OWN_DBG;
         rom_addr = dbg_addr;
      end else if (cpu_req) begin
         winner   = OWN_CPU;
         rom_addr = cpu_addr;
      end else if (dbg_valid) begin
         winner   = OWN_DBG;
         rom_addr = dbg_addr;
      end else if (scan_st == S_RUN) begin
         winner   = OWN_SCAN;
         rom_addr = scan_addr;
      end
   end

   assign cpu_stall  = cpu_req && (winner != OWN_CPU);
   assign dbg_ready  = (winner == OWN_DBG);

   // Returned word is steered by the tag of the read issued last cycle.
   assign cpu_ir_vld = (tag_q == OWN_CPU);
   assign dbg_dvld   = (tag_q == OWN_DBG);
   assign cpu_ir     = cpu_ir_vld ? rom_data : cpu_ir_q;
   assign dbg_data   = dbg_dvld ? rom_data : dbg_data_q;

   assign scan_acc_nxt = (tag_q == OWN_SCAN) ? scan_acc + rom_data : scan_acc;

   always_ff @(posedge prog_clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q      <= OWN_NONE;
         rom_addr_q <= '0;
         cpu_ir_q   <= '0;
         dbg_data_q <= '0;
         wait_cnt   <= '0;
      end else begin
         tag_q      <= winner;
         rom_addr_q <= rom_addr;
         cpu_ir_q   <= cpu_ir;
         dbg_data_q <= dbg_data;
         if (!dbg_valid || (winner == OWN_DBG))
            wait_cnt <= '0;
         else if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + WW'(1);
      end
   end

   always_ff @(posedge prog_clk or negedge rst_n) begin
      if (!rst_n) scan_st <= S_IDLE;
      else        scan_st <= scan_nxt;
   end

   always_comb begin
      scan_nxt  = scan_st;
      scan_busy = 1'b0;
      scan_done = 1'b0;
      case (scan_st)
         S_IDLE: begin
            if (scan_start) scan_nxt = S_RUN;
         end
         S_RUN: begin
            scan_busy = 1'b1;
            if ((winner == OWN_SCAN) && (scan_addr == SCAN_LAST)) scan_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            scan_busy = 1'b1;
            scan_nxt  = S_DONE;
         end
         S_DONE: begin
            scan_done = 1'b1;
            scan_nxt  = S_IDLE;
         end
         default: scan_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_addr <= '0;
         scan_acc  <= '0;
         scan_sum  <= '0;
      end else begin
         if ((scan_st == S_IDLE) && scan_start) begin
            scan_addr <= '0;
            scan_acc  <= '0;
         end else begin
            if (winner == OWN_SCAN) scan_addr <= scan_addr + AW'(1);
            scan_acc <= scan_acc_nxt;
         end
         // DRAIN carries the final word, so the published sum includes it.
         if (scan_st == S_DRAIN) scan_sum <= scan_acc_nxt;
      end
   end

endmodule

// File: tb/tb_prog_rom_port_sched.sv
module tb_prog_rom_port_sched;
   localparam int AW = 10;
   localparam int DW = 18;

   logic          prog_clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, dbg_valid, scan_start;
   logic [AW-1:0] cpu_addr, dbg_addr, rom_addr;
   logic          cpu_stall, cpu_ir_vld, dbg_ready, dbg_dvld, scan_busy, scan_done;
   logic [DW-1:0] cpu_ir, dbg_data, scan_sum, rom_data;

   logic [DW-1:0] rom [0:1023];
   logic [DW-1:0] cpu_q[$];
   logic [DW-1:0] dbg_q[$];
   bit            cpu_pend, dbg_pend;
   int            n_chk = 0;
   int            n_fail = 0;

   always #5 prog_clk = ~prog_clk;

   always @(posedge prog_clk) rom_data <= rom[rom_addr];

   prog_rom_port_sched #(.AW(AW), .DW(DW), .DEPTH(1024), .MAX_WAIT(16)) dut (
      .prog_clk(prog_clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
      .cpu_ir(cpu_ir), .cpu_ir_vld(cpu_ir_vld),
      .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
      .dbg_data(dbg_data), .dbg_dvld(dbg_dvld),
      .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
      .scan_sum(scan_sum), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, then score whatever the DUT returned for last cycle's grant.
   task automatic tick();
      logic [DW-1:0] e;
      @(posedge prog_clk);
      #1;
      chk("cpu_ir_vld", 32'(cpu_ir_vld), 32'(cpu_pend));
      if (cpu_pend) begin
         e = cpu_q.pop_front();
         chk("cpu_ir", 32'(cpu_ir), 32'(e));
      end
      chk("dbg_dvld", 32'(dbg_dvld), 32'(dbg_pend));
      if (dbg_pend) begin
         e = dbg_q.pop_front();
         chk("dbg_data", 32'(dbg_data), 32'(e));
      end
      cpu_pend = 1'b0;
      dbg_pend = 1'b0;
   endtask

   task automatic push_cpu(input logic [AW-1:0] a);
      cpu_q.push_back(rom[a]);
      cpu_pend = 1'b1;
   endtask

   task automatic push_dbg(input logic [AW-1:0] a);
      dbg_q.push_back(rom[a]);
      dbg_pend = 1'b1;
   endtask

   task automatic chk_zero();
      chk("rst_cpu_stall", 32'(cpu_stall), 0);
      chk("rst_cpu_ir", 32'(cpu_ir), 0);
      chk("rst_cpu_ir_vld", 32'(cpu_ir_vld), 0);
      chk("rst_dbg_ready", 32'(dbg_ready), 0);
      chk("rst_dbg_data", 32'(dbg_data), 0);
      chk("rst_dbg_dvld", 32'(dbg_dvld), 0);
      chk("rst_scan_busy", 32'(scan_busy), 0);
      chk("rst_scan_done", 32'(scan_done), 0);
      chk("rst_scan_sum", 32'(scan_sum), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
   endtask

   // exp_cycles = 0 skips the latency check (when fetch traffic interleaves).
   task automatic run_scan(input int exp_cycles, input logic [DW-1:0] exp_sum,
                           input bit cpu_traffic, input bit restart_mid);
      int            n;
      bit            done;
      logic [AW-1:0] pc;
      n = 0; done = 1'b0; pc = '0;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      n = 1;
      chk("scan_busy_start", 32'(scan_busy), 1);
      while (!done && n < 4000) begin
         if (cpu_traffic) begin
            cpu_req  = n[0];
            cpu_addr = pc;
            #1;
            if (cpu_req) begin
               chk("scan_cpu_stall", 32'(cpu_stall), 0);
               push_cpu(pc);
               pc++;
            end
         end
         scan_start = restart_mid && (n == 500);
         tick();
         n++;
         if (scan_done) done = 1'b1;
      end
      cpu_req    = 1'b0;
      scan_start = 1'b0;
      chk("scan_done_seen", 32'(done), 1);
      if (exp_cycles > 0) chk("scan_latency", 32'(n), 32'(exp_cycles));
      chk("scan_sum", 32'(scan_sum), 32'(exp_sum));
      tick();
      chk("scan_done_pulse", 32'(scan_done), 0);
      chk("scan_busy_end", 32'(scan_busy), 0);
      chk("scan_sum_hold", 32'(scan_sum), 32'(exp_sum));
   endtask

   initial begin
      logic [AW-1:0] pc;
      rst_n = 1'b1;
      cpu_req = 1'b0; cpu_addr = '0;
      dbg_valid = 1'b0; dbg_addr = '0;
      scan_start = 1'b0;
      cpu_pend = 1'b0; dbg_pend = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = 18'(i + 'h100);
      rom[10'h3FF] = 18'h2ABCD;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge prog_clk);
      #1;
      chk_zero();
      rst_n = 1'b1;

      // Back-to-back fetch, one-cycle lag, no stall.
      for (int i = 0; i < 8; i++) begin
         cpu_req  = 1'b1;
         cpu_addr = AW'(i);
         #1;
         chk("seq_stall", 32'(cpu_stall), 0);
         chk("seq_rom_addr", 32'(rom_addr), 32'(i));
         push_cpu(AW'(i));
         tick();
      end
      cpu_req = 1'b0;
      tick();
      chk("cpu_ir_hold", 32'(cpu_ir), 32'h107);

      // Debug read with an idle CPU.
      dbg_valid = 1'b1;
      dbg_addr  = 10'h3FF;
      #1;
      chk("dbg_ready_idle", 32'(dbg_ready), 1);
      chk("dbg_rom_addr", 32'(rom_addr), 32'h3FF);
      push_dbg(10'h3FF);
      tick();
      dbg_valid = 1'b0;
      tick();
      chk("dbg_data_hold", 32'(dbg_data), 32'h2ABCD);

      // Debug withdrawn while blocked by fetch: no data, wait count cleared.
      pc = 10'd40;
      for (int k = 0; k < 4; k++) begin
         cpu_req   = 1'b1;
         cpu_addr  = pc;
         dbg_valid = (k < 3);
         dbg_addr  = 10'h3FF;
         #1;
         chk("wd_dbg_ready", 32'(dbg_ready), 0);
         chk("wd_stall", 32'(cpu_stall), 0);
         push_cpu(pc);
         pc++;
         tick();
      end

      // Forced debug slot after MAX_WAIT blocked cycles.
      pc = '0;
      for (int k = 0; k < 20; k++) begin
         cpu_req   = 1'b1;
         cpu_addr  = pc;
         dbg_valid = (k <= 16);
         dbg_addr  = 10'h3FF;
         #1;
         chk("fs_stall", 32'(cpu_stall), 32'(k == 16));
         chk("fs_dbg_ready", 32'(dbg_ready), 32'(k == 16));
         if (k == 16) begin
            chk("fs_rom_addr_dbg", 32'(rom_addr), 32'h3FF);
            push_dbg(10'h3FF);
         end else begin
            chk("fs_rom_addr_cpu", 32'(rom_addr), 32'(pc));
            push_cpu(pc);
            pc++;
         end
         tick();
      end
      cpu_req   = 1'b0;
      dbg_valid = 1'b0;
      tick();

      // Full scan of ones, with a start pulse mid-scan that must be ignored.
      for (int i = 0; i < 1024; i++) rom[i] = 18'h00001;
      run_scan(1026, 18'h00400, 1'b0, 1'b1);

      // Scan sharing the port with fetch every other cycle; sum wraps.
      for (int i = 0; i < 1024; i++) rom[i] = 18'h3FFFF;
      run_scan(0, 18'h3FC00, 1'b1, 1'b0);

      // Reset during a scan and during a debug grant.
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      repeat (100) tick();
      dbg_valid = 1'b1;
      dbg_addr  = 10'd5;
      #1;
      chk("rst_dbg_granted", 32'(dbg_ready), 1);
      rst_n = 1'b0;
      #1;
      dbg_valid = 1'b0;
      #1;
      chk_zero();
      tick();
      tick();
      chk_zero();
      rst_n = 1'b1;
      for (int i = 0; i < 1024; i++) rom[i] = 18'h00001;
      run_scan(1026, 18'h00400, 1'b0, 1'b0);

      chk("cpu_q_empty", 32'(cpu_q.size()), 0);
      chk("dbg_q_empty", 32'(dbg_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
